mmio_game_io: RTL and testbench
===============================

# mmio_game_io

Memory-mapped game I/O peripheral sitting between the processor's data-memory port and the board's buttons and LEDs. It generalises the single random/LED/button address decode to `NUM_CH` channels. It adds:
- per-channel debouncing,
- a latched, read-to-clear button event register with overrun detection,
- timed auto-off LED flashes,
- a seedable LFSR that advances on every read.

The wrapper muxes `data_out` into the processor's load data whenever `hit` is high.

## Interface
Parameters:
- `NUM_CH`, 4 — number of button/LED channels (2..16).
- `BASE_ADDR`, 12'd5 — first of the four word addresses claimed.
- `DEBOUNCE_CYCLES`, 500000 — stable cycles required before a level change is accepted (10 ms at 50 MHz).
- `FLASH_CYCLES`, 12500000 — on-time of a timed flash.
- `LFSR_SEED`, 32'hACE1_0001 — LFSR reset value; must be nonzero.

Ports:
- `clock`  in  1  — single system clock; all state changes on its rising edge.
- `reset`  in  1  — reset; synchronous and active-low (sampled on the `clock` edge).
- `wren`  in  1  — store strobe from the processor.
- `rden`  in  1  — load strobe, decoded by the wrapper from the processor's lw.
- `addr`  in  12  — data-memory word address.
- `data_in`  in  32  — store data.
- `data_out`  out  32  — read data, combinational from `addr`; zero when `hit` is low.
- `hit`  out  1  — `addr` is within `BASE_ADDR..BASE_ADDR+3`.
- `buttons`  in  `NUM_CH`  — raw, asynchronous, active-high buttons.
- `leds`  out  `NUM_CH`  — registered, active-high LED drives.

## Operation
Register map (offsets from `BASE_ADDR`):
- **+0 RANDOM** (read)
  - Returns the current 32-bit Galois LFSR value (taps 32,22,2,1).
  - The LFSR advances one step on each cycle where `rden` && addr==+0, and also free-runs one step every cycle.
  - A read therefore never returns the same value twice in a row.
- **+1 LED** (write; reads as the current `leds` value)
  - bit0 = on/off.
  - bits[4:1] = channel index.
  - bit31 = mode: 0 steady, 1 timed flash.
  - Index ≥ `NUM_CH`: write ignored.
  - Steady write: sets or clears the LED and cancels any running flash on that channel.
  - Timed write with bit0=1: LED on, counter loaded with `FLASH_CYCLES`; the LED clears when the counter reaches 0.
  - A timed write during a flash on the same channel reloads the counter.
  - Timed write with bit0=0: behaves as a steady off.
- **+2 EVENT** (read-to-clear)
  - bit31 = pending.
  - bit30 = overrun.
  - bits[3:0] = index of the channel whose debounced rising edge was latched.
  - An edge while pending=0 latches the index.
  - Simultaneous edges latch the lowest index; the others set overrun.
  - An edge while pending=1 sets overrun; the index is kept.
  - `rden` && addr==+2 clears pending and overrun on the next edge.
  - If an edge coincides with the clearing read, the new event is latched (pending=1, overrun=0).
- **+3 LEVEL** (read)
  - bits[NUM_CH-1:0] = debounced button levels. Read-only; stores are ignored.

Debounce, per channel:
- 2-flop synchroniser, then a counter that resets on any mismatch with the accepted level.
- The new level is accepted when the counter reaches `DEBOUNCE_CYCLES`.
- A rising edge is an accepted 0→1 transition.

Stores to +0, +2 and +3 are ignored.

## Timing
- **Reset** (`reset`=0 at an edge): `leds`=0, pending=0, overrun=0, flash counters=0, debounce levels=0, LFSR=`LFSR_SEED`. `data_out` and `hit` are combinational and follow `addr`.
- **Button latency:** a raw press stable from cycle t is latched in EVENT at edge t+2+`DEBOUNCE_CYCLES`, visible the same cycle on `data_out`.
- **LED write latency:** `leds` changes at the edge after the `wren` cycle. A timed flash is high for exactly `FLASH_CYCLES` cycles.
- **Reads** return pre-edge state; read side effects (clear, LFSR step) take effect at the edge ending the read cycle.
- **Reset mid-flash or mid-debounce:** everything aborts to reset values, with no spurious event after reset release while buttons stay low.

## Structure
- Package `io_map_pkg`:
  - offset constants `OFF_RANDOM`/`OFF_LED`/`OFF_EVENT`/`OFF_LEVEL`;
  - LED field positions `LED_ON_BIT`, `LED_IDX_LSB/MSB`, `LED_MODE_BIT`;
  - EVENT field positions `EV_PEND_BIT`, `EV_OVR_BIT`;
  - LFSR tap mask.
- Sub-module `io_debounce` (synchroniser, counter, accepted level, rise pulse), instantiated `NUM_CH` times in a generate loop.
- The top level holds the decode, LED/flash logic, event latch, priority encoder and LFSR.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `FLASH_CYCLES`=10, `NUM_CH`=4.

- **Debounce timing:** glitch `buttons[2]` high for 3 cycles → EVENT reads 0. Hold high 10 cycles → EVENT reads 32'h8000_0002 at cycle 6 after rise.
- **Read-to-clear and overrun:** press ch1, then ch3 before reading → EVENT=32'hC000_0001. A read clears it, and the next read = 0. Simultaneous ch0+ch3 press → 32'hC000_0000.
- **Clear-vs-edge collision:** read EVENT in the same cycle ch2's debounced edge occurs → the following read = 32'h8000_0002.
- **LED flash:** store 32'h8000_0005 to +1 → `leds`=4'b0100 for exactly 10 cycles, then 0. Re-store at cycle 5 → total 15 cycles. Steady store 0x4 mid-flash → LED off next edge and stays off.
- **Out of range and reset:** store index 7 → `leds` unchanged. Two consecutive RANDOM reads differ. Assert `reset` low for one edge during a flash → `leds`=0 and RANDOM=`LFSR_SEED` on the next read.

Source files
------------

// File: rtl/io_map_pkg.sv
// Register map, field positions and LFSR helper shared by the game I/O peripheral.
package io_map_pkg;

  typedef enum logic [1:0] {
    OFF_RANDOM = 2'd0,
    OFF_LED    = 2'd1,
    OFF_EVENT  = 2'd2,
    OFF_LEVEL  = 2'd3
  } reg_off_e;

  localparam int unsigned LED_ON_BIT   = 0;
  localparam int unsigned LED_IDX_LSB  = 1;
  localparam int unsigned LED_IDX_MSB  = 4;
  localparam int unsigned LED_MODE_BIT = 31;

  localparam int unsigned EV_PEND_BIT = 31;
  localparam int unsigned EV_OVR_BIT  = 30;

  // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, accepted level and rise pulse.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          accept;
  logic [CW-1:0] cnt;

  // The level flips on the edge that would bring the mismatch count to DEBOUNCE_CYCLES.
  always_comb begin
    accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    rise   = accept && sync2;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level || accept) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
      if (accept) level <= sync2;
    end
  end

endmodule

// File: rtl/mmio_game_io.sv
// Memory-mapped game I/O: LFSR random source, timed LEDs, debounced button events and levels.
module mmio_game_io
  import io_map_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter logic [11:0] BASE_ADDR       = 12'd5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FLASH_CYCLES    = 12500000,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic              rden,
  input  logic [11:0]       addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              hit,
  input  logic [NUM_CH-1:0] buttons,
  output logic [NUM_CH-1:0] leds
);

  localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);

  logic [11:0]       rel_addr;
  reg_off_e          off;
  logic [3:0]        led_idx;
  logic              led_wr;
  logic              rand_rd;
  logic              ev_clr;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic              edge_any;
  logic              edge_multi;
  logic              edge_found;
  logic [3:0]        first_idx;
  logic              ev_pend;
  logic              ev_ovr;
  logic [3:0]        ev_idx;
  logic [31:0]       lfsr;
  logic [FW-1:0]     flash_cnt [NUM_CH];
  logic              unused_data;

  assign unused_data = ^data_in[LED_MODE_BIT-1:LED_IDX_MSB+1];

  // Wrap-around subtraction keeps the window test a single compare.
  always_comb begin
    rel_addr = addr - BASE_ADDR;
    hit      = rel_addr < 12'd4;
    off      = reg_off_e'(rel_addr[1:0]);
    led_idx  = data_in[LED_IDX_MSB:LED_IDX_LSB];
    led_wr   = wren && hit && (off == OFF_LED) && (32'(led_idx) < NUM_CH);
    rand_rd  = rden && hit && (off == OFF_RANDOM);
    ev_clr   = rden && hit && (off == OFF_EVENT);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (buttons[g]),
      .level(level[g]),
      .rise (rise[g])
    );
  end

  always_comb begin
    edge_any   = |rise;
    edge_multi = |(rise & (rise - NUM_CH'(1)));
    edge_found = 1'b0;
    first_idx  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rise[i] && !edge_found) begin
        first_idx  = 4'(i);
        edge_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      leds <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) flash_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (led_wr && led_idx == 4'(i)) begin
          if (data_in[LED_MODE_BIT] && data_in[LED_ON_BIT]) begin
            leds[i]      <= 1'b1;
            flash_cnt[i] <= FW'(FLASH_CYCLES);
          end else begin
            leds[i]      <= data_in[LED_ON_BIT];
            flash_cnt[i] <= '0;
          end
        end else if (flash_cnt[i] != '0) begin
          flash_cnt[i] <= flash_cnt[i] - FW'(1);
          if (flash_cnt[i] == FW'(1)) leds[i] <= 1'b0;
        end
      end
    end
  end

  // A clearing read that coincides with an edge hands over straight to the new event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ev_pend <= 1'b0;
      ev_ovr  <= 1'b0;
      ev_idx  <= '0;
    end else if (ev_clr) begin
      ev_pend <= edge_any;
      ev_ovr  <= edge_multi;
      ev_idx  <= edge_any ? first_idx : '0;
    end else if (edge_any) begin
      if (!ev_pend) begin
        ev_pend <= 1'b1;
        ev_ovr  <= edge_multi;
        ev_idx  <= first_idx;
      end else begin
        ev_ovr  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)       lfsr <= LFSR_SEED;
    else if (rand_rd) lfsr <= lfsr_step(lfsr_step(lfsr));
    else              lfsr <= lfsr_step(lfsr);
  end

  always_comb begin
    data_out = '0;
    if (hit) begin
      case (off)
        OFF_RANDOM: data_out = lfsr;
        OFF_LED:    data_out[NUM_CH-1:0] = leds;
        OFF_EVENT: begin
          data_out[EV_PEND_BIT] = ev_pend;
          data_out[EV_OVR_BIT]  = ev_ovr;
          data_out[3:0]         = ev_idx;
        end
        OFF_LEVEL:  data_out[NUM_CH-1:0] = level;
        default:    data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_game_io.sv
// Self-checking bench for mmio_game_io: decode table, directed corner cases, random run vs model.
module tb_mmio_game_io;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned FL   = 10;
  localparam logic [11:0] BASE = 12'd5;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           wren = 1'b0;
  logic           rden = 1'b0;
  logic [11:0]    addr = '0;
  logic [31:0]    data_in = '0;
  logic [31:0]    data_out;
  logic           hit;
  logic [NCH-1:0] buttons = '0;
  logic [NCH-1:0] leds;

  mmio_game_io #(
    .NUM_CH(NCH), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB),
    .FLASH_CYCLES(FL), .LFSR_SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .rden(rden), .addr(addr),
    .data_in(data_in), .data_out(data_out), .hit(hit), .buttons(buttons), .leds(leds)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [31:0] m_lfsr;
  logic [3:0]  m_steady;
  int          m_deadline [NCH];
  int          now;
  logic        m_pend, m_ovr;
  logic [3:0]  m_idx;
  logic [3:0]  m_level;
  logic [3:0]  q_raw [$];

  logic [31:0] obs_data;
  logic        obs_hit;
  logic [3:0]  obs_leds;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // x^32 + x^22 + x^2 + x + 1, shifting towards bit 0
  function automatic logic [31:0] galois(input logic [31:0] v);
    int exps [4] = '{32, 22, 2, 1};
    logic [31:0] poly = '0;
    foreach (exps[k]) poly[exps[k]-1] = 1'b1;
    return v[0] ? ((v >> 1) ^ poly) : (v >> 1);
  endfunction

  function automatic logic [3:0] m_leds();
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_steady[i] || (now < m_deadline[i]);
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input logic [11:0] a);
    logic [11:0] o = a - BASE;
    logic [31:0] r = '0;
    if (o < 4) begin
      case (o)
        12'd0: r = m_lfsr;
        12'd1: r[3:0] = m_leds();
        12'd2: r = {m_pend, m_ovr, 26'd0, m_idx};
        default: r[3:0] = m_level;
      endcase
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_lfsr = SEED; m_steady = '0; m_pend = 1'b0; m_ovr = 1'b0; m_idx = '0; m_level = '0;
    for (int i = 0; i < NCH; i++) m_deadline[i] = 0;
    q_raw.delete();
    for (int i = 0; i < DB + 2; i++) q_raw.push_back(4'b0);
  endfunction

  // Applies one clock edge worth of behaviour using the inputs present at that edge.
  function automatic void model_step();
    logic [3:0] rises = '0;
    logic [3:0] low = '0;
    int nr;
    now++;
    if (!reset) begin
      model_reset();
      return;
    end
    m_lfsr = galois(m_lfsr);
    if (rden && addr == BASE) m_lfsr = galois(m_lfsr);
    if (wren && addr == BASE + 12'd1 && data_in[4:1] < NCH) begin
      if (data_in[31] && data_in[0]) begin
        m_steady[data_in[4:1]]   = 1'b0;
        m_deadline[data_in[4:1]] = now + FL;
      end else begin
        m_steady[data_in[4:1]]   = data_in[0];
        m_deadline[data_in[4:1]] = 0;
      end
    end
    // level flips once the synchronised input has disagreed with it for DB cycles
    q_raw.push_back(buttons);
    void'(q_raw.pop_front());
    for (int c = 0; c < NCH; c++) begin
      bit stable = 1'b1;
      for (int j = 0; j < DB; j++) if (q_raw[j][c] == m_level[c]) stable = 1'b0;
      if (stable) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) rises[c] = 1'b1;
      end
    end
    nr = $countones(rises);
    for (int c = NCH - 1; c >= 0; c--) if (rises[c]) low = 4'(c);
    if (rden && addr == BASE + 12'd2) begin
      m_pend = nr > 0; m_ovr = nr > 1; m_idx = (nr > 0) ? low : 4'd0;
    end else if (nr > 0) begin
      if (!m_pend) begin
        m_pend = 1'b1; m_ovr = nr > 1; m_idx = low;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  task automatic drive(input logic rst, input logic we, input logic re, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(negedge clock);
    reset = rst; wren = we; rden = re; addr = a; data_in = d; buttons = b;
    #1;
    chk("hit", {31'd0, hit}, {31'd0, (a - BASE) < 12'd4});
    chk("leds", {28'd0, leds}, {28'd0, m_leds()});
    chk("data_out", data_out, exp_data(a));
    obs_data = data_out; obs_hit = hit; obs_leds = leds;
    @(posedge clock);
    model_step();
  endtask

  task automatic idle(input int n, input logic [3:0] b);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, b);
  endtask

  task automatic peek_ev(input string name, input logic [3:0] b, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b0, BASE + 12'd2, 32'd0, b);
    chk(name, obs_data, exp);
  endtask

  task automatic read_ev(input string name, input logic [3:0] b, input logic [31:0] exp);
    drive(1'b1, 1'b0, 1'b1, BASE + 12'd2, 32'd0, b);
    chk(name, obs_data, exp);
  endtask

  task automatic wr_led(input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b0, BASE + 12'd1, d, 4'b0);
  endtask

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic        hit;
    logic [3:0]  leds;
  } vec_t;

  vec_t tbl [13];
  logic [31:0] r1, r2;
  int ncount;

  initial begin
    tbl[0]  = '{12'd6,   32'h0000_0001, 1'b1, 4'b0001};
    tbl[1]  = '{12'd6,   32'h0000_0007, 1'b1, 4'b1001};
    tbl[2]  = '{12'd6,   32'h0000_0006, 1'b1, 4'b0001};
    tbl[3]  = '{12'd5,   32'h0000_0003, 1'b1, 4'b0001};
    tbl[4]  = '{12'd7,   32'h0000_0003, 1'b1, 4'b0001};
    tbl[5]  = '{12'd8,   32'h0000_0003, 1'b1, 4'b0001};
    tbl[6]  = '{12'd4,   32'h0000_0003, 1'b0, 4'b0001};
    tbl[7]  = '{12'd9,   32'h0000_0003, 1'b0, 4'b0001};
    tbl[8]  = '{12'd6,   32'h0000_0009, 1'b1, 4'b0001};
    tbl[9]  = '{12'd6,   32'h0000_001F, 1'b1, 4'b0001};
    tbl[10] = '{12'd6,   32'h0000_0000, 1'b1, 4'b0000};
    tbl[11] = '{12'd6,   32'h8000_0003, 1'b1, 4'b0010};
    tbl[12] = '{12'h806, 32'h0000_0005, 1'b0, 4'b0010};

    now = 0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'b0);
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'b0);
    chk("reset_leds", {28'd0, obs_leds}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, BASE, 32'd0, 4'b0);
    chk("reset_random", obs_data, SEED);
    peek_ev("reset_event", 4'b0, 32'd0);

    // Decode / LED write table
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b1, 1'b0, tbl[i].a, tbl[i].d, 4'b0);
      chk($sformatf("tbl%0d_hit", i), {31'd0, obs_hit}, {31'd0, tbl[i].hit});
      idle(1, 4'b0);
      chk($sformatf("tbl%0d_leds", i), {28'd0, obs_leds}, {28'd0, tbl[i].leds});
    end
    idle(12, 4'b0);
    wr_led(32'h0000_0002);

    // Debounce: short glitch ignored, long press latched on the 6th cycle
    idle(3, 4'b0);
    idle(3, 4'b0100);
    idle(10, 4'b0);
    read_ev("glitch_ev", 4'b0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, BASE + 12'd2, 32'd0, 4'b0100);
      if (k == 5) chk("press_c5", obs_data, 32'd0);
      if (k == 6) chk("press_c6", obs_data, 32'h8000_0002);
    end
    drive(1'b1, 1'b0, 1'b0, BASE + 12'd3, 32'd0, 4'b0100);
    chk("level_ch2", obs_data, 32'h0000_0004);
    read_ev("press_read", 4'b0100, 32'h8000_0002);
    peek_ev("press_cleared", 4'b0100, 32'd0);

    // Overrun
    idle(8, 4'b0);
    idle(8, 4'b0010);
    idle(8, 4'b1010);
    read_ev("ovr_read", 4'b1010, 32'hC000_0001);
    peek_ev("ovr_cleared", 4'b1010, 32'd0);
    idle(8, 4'b0);
    idle(8, 4'b1001);
    read_ev("simul_read", 4'b1001, 32'hC000_0000);
    peek_ev("simul_cleared", 4'b1001, 32'd0);

    // Clear coinciding with a new edge
    idle(8, 4'b0);
    idle(8, 4'b0010);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 4'b0110);
    read_ev("coll_read", 4'b0110, 32'h8000_0001);
    read_ev("coll_next", 4'b0110, 32'h8000_0002);
    peek_ev("coll_after", 4'b0110, 32'd0);
    idle(8, 4'b0);

    // Flash exactly FL cycles
    wr_led(32'h8000_0005);
    for (int k = 1; k <= 12; k++) begin
      idle(1, 4'b0);
      chk($sformatf("flash_k%0d", k), {28'd0, obs_leds}, (k <= 10) ? 32'h4 : 32'h0);
    end
    // Reload at cycle 5 stretches to 15
    wr_led(32'h8000_0005);
    ncount = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) wr_led(32'h8000_0005);
      else idle(1, 4'b0);
      if (obs_leds == 4'b0100) ncount++;
    end
    chk("reload_len", ncount, 15);
    // Steady off mid-flash
    wr_led(32'h8000_0005);
    idle(2, 4'b0);
    wr_led(32'h0000_0004);
    ncount = 0;
    for (int k = 0; k < 12; k++) begin
      idle(1, 4'b0);
      if (obs_leds != 4'b0) ncount++;
    end
    chk("steady_off", ncount, 0);

    // Out of range, RANDOM, reset mid-flash/mid-debounce
    wr_led(32'h0000_0003);
    wr_led(32'h0000_000F);
    idle(1, 4'b0);
    chk("oor_leds", {28'd0, obs_leds}, 32'h2);
    drive(1'b1, 1'b0, 1'b1, BASE, 32'd0, 4'b0);
    r1 = obs_data;
    drive(1'b1, 1'b0, 1'b1, BASE, 32'd0, 4'b0);
    r2 = obs_data;
    chk("rand_differ", {31'd0, r1 != r2}, 32'd1);
    wr_led(32'h8000_0001);
    idle(3, 4'b0001);
    drive(1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 4'b0);
    drive(1'b1, 1'b0, 1'b1, BASE, 32'd0, 4'b0);
    chk("rst_random", obs_data, SEED);
    chk("rst_leds", {28'd0, obs_leds}, 32'd0);
    idle(12, 4'b0);
    peek_ev("rst_no_event", 4'b0, 32'd0);

    // Randomized run against the model
    begin
      logic [3:0] b = '0;
      for (int n = 0; n < 1500; n++) begin
        logic [31:0] d;
        for (int c = 0; c < NCH; c++) if ($urandom_range(0, 9) == 0) b[c] = ~b[c];
        d = $urandom;
        d[4:1] = 4'($urandom_range(0, 7));
        drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1,
              BASE - 12'd1 + 12'($urandom_range(0, 5)), d, b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
